// File: rtl/rf_pkg.sv
// Shared defaults and index/word types for the scoreboarded register file.
package rf_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;
    localparam int unsigned NRD_DEF   = 2;
    localparam int unsigned AW_DEF    = $clog2(NREGS_DEF);

    typedef logic [AW_DEF-1:0]   reg_idx_t;
    typedef logic [XLEN_DEF-1:0] xword_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on writeback,
// plus a sticky error flag for double issue or unexpected writeback.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic             iss_en_i,
    input  logic [AW-1:0]    iss_rd_i,
    output logic [NREGS-1:0] pend_o,
    output logic             err_o
);

    logic [NREGS-1:0] pend_q, pend_d;
    logic             err_q, err_d;
    logic             iss_v, wr_v, same_v, iss_err, wr_err;

    always_comb begin
        iss_v  = iss_en_i && (iss_rd_i != '0);
        wr_v   = wr_en_i && (wr_addr_i != '0);
        same_v = iss_v && wr_v && (iss_rd_i == wr_addr_i);
        // Same-cycle issue+writeback to one register is a legal handoff, not an error.
        iss_err = iss_v && pend_q[iss_rd_i] && !same_v;
        wr_err  = wr_v && !pend_q[wr_addr_i] && !same_v;

        pend_d = pend_q;
        if (wr_v) begin
            pend_d[wr_addr_i] = 1'b0;
        end
        if (iss_v) begin
            pend_d[iss_rd_i] = 1'b1;
        end
        pend_d[0] = 1'b0;

        err_d = err_q | iss_err | wr_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    assign pend_o = pend_q;
    assign err_o  = err_q;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with pending-write scoreboard; x0 is hardwired to zero.
// Define RF_BYPASS_EN to forward same-cycle writeback data (and clear busy) on reads.
module reg_file_sb
    import rf_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned NRD   = NRD_DEF
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NRD-1:0][$clog2(NREGS)-1:0]    rs_addr_i,
    output logic [NRD-1:0][XLEN-1:0]             rs_data_o,
    output logic [NRD-1:0]                       rs_busy_o,
    input  logic                                 wr_en_i,
    input  logic [$clog2(NREGS)-1:0]             wr_addr_i,
    input  logic [XLEN-1:0]                      wr_data_i,
    input  logic                                 iss_en_i,
    input  logic [$clog2(NREGS)-1:0]             iss_rd_i,
    output logic                                 err_o
);

    localparam int unsigned AW = $clog2(NREGS);

`ifdef RF_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
    logic [NREGS-1:0]           pend;
    logic                       wr_v;

    assign wr_v = wr_en_i && (wr_addr_i != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_v) begin
            regs_d[wr_addr_i] = wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Bypass is gated by rst_n so every output reads zero while reset is held.
    always_comb begin
        rs_data_o = '0;
        rs_busy_o = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            rs_data_o[k] = regs_q[rs_addr_i[k]];
            rs_busy_o[k] = pend[rs_addr_i[k]];
            if (Bypass && rst_n && wr_v && (rs_addr_i[k] == wr_addr_i)) begin
                rs_data_o[k] = wr_data_i;
                rs_busy_o[k] = 1'b0;
            end
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_en_i),
        .wr_addr_i (wr_addr_i),
        .iss_en_i  (iss_en_i),
        .iss_rd_i  (iss_rd_i),
        .pend_o    (pend),
        .err_o     (err_o)
    );

endmodule
